wddl_dr_rx: RTL and testbench
=============================

Name: wddl_dr_rx

Overview:
- Receiving end of a WDDL dual-rail precharge/evaluate link: sits at the output of a WDDL gate network (wddl_or, etc.) and converts (true, false) rail pairs back to single-rail data.
- Tracks the precharge/evaluate cycle driven by prechrg_i and detects completion of every pair during evaluate.
- Captures the result into a 1-entry valid/ready output buffer.
- Flags and counts protocol violations: illegal 11 pairs, incomplete evaluation, rails not cleared after precharge, and output overrun.

Parameters:
- WIDTH, 4: number of dual-rail pairs (single-rail data width).
- TIMEOUT, 8: maximum evaluate cycles allowed before completion; legal range 1..255.
- ERRCNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- prechrg_i  in  1  1 = precharge phase (all rails must return to 0); 0 = evaluate phase.
- t_i  in  WIDTH  true rails.
- f_i  in  WIDTH  false rails.
- data_o  out  WIDTH  captured single-rail data (= t_i at completion).
- valid_o  out  1  data_o holds unconsumed data.
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i.
- err_o  out  1  one-cycle error pulse.
- err_code_o  out  3  cause of the last error; meaningful only while err_o = 1.
- err_cnt_o  out  ERRCNT_W  saturating count of errors.

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - data_o = 0, valid_o = 0, err_o = 0, err_code_o = 0, err_cnt_o = 0.
  - Evaluate counter = 0; state = WAIT_PRE.
  - Reset mid-operation discards any pending data and any in-flight evaluation.
- Per-pair decode: 00 = empty, 10 = logic 1, 01 = logic 0, 11 = illegal.
- complete = every pair is exactly 10 or 01. zero = all t_i and f_i bits are 0.
- FSM:
  - WAIT_PRE: go to PRE when prechrg_i = 1. Rail values are ignored in this state.
  - PRE: rails may still be discharging; no check while prechrg_i = 1.
    - On prechrg_i = 0 with zero = 1: go to EVAL and clear the counter.
    - On prechrg_i = 0 with zero = 0: error 011 (precharge violation), go to WAIT_PRE.
  - EVAL: the counter increments each cycle. Priority, highest first:
    - (1) Any pair 11: error 001, go to WAIT_PRE.
    - (2) complete: capture t_i, go to DONE.
    - (3) Counter reaches TIMEOUT, or prechrg_i = 1 (premature precharge): error 010, go to WAIT_PRE. If prechrg_i = 1 triggered the error, the next state is still WAIT_PRE, and it advances to PRE on the following cycle.
  - DONE: go to PRE when prechrg_i = 1. Rails are ignored.
- Capture latency: complete sampled at edge N → data_o updated and valid_o = 1 after edge N+1.
- Output buffer:
  - valid_o && ready_i clears valid_o unless a capture happens in the same cycle; a same-cycle capture wins, so valid_o stays 1 with the new data.
  - Capture while valid_o = 1 && ready_i = 0: data is dropped, data_o and valid_o are unchanged, error 100 (overrun).
  - data_o is stable whenever valid_o = 1 && ready_i = 0.
- Errors:
  - err_o pulses for exactly 1 cycle, registered together with err_code_o.
  - err_cnt_o increments by 1 per error and saturates at all-ones.
  - Only one error per cycle; the overrun and FSM-error conditions are mutually exclusive by construction.
  - err_code_o holds its last value while err_o = 0.

Optional Feature:
- Macro WDDL_RX_SYNC_EN.
  - Defined: prechrg_i, t_i and f_i each pass through a 2-flop synchronizer before the FSM. Capture latency becomes 3 cycles from input change. The synchronizer flops reset to 0.
  - Undefined: inputs feed the FSM directly; latency as stated above.
- Test-plan cycle counts assume the macro is undefined; add 2 cycles when it is defined.

Test Plan:
- Normal capture: WIDTH=4, full precharge with rails 0. Then prechrg_i = 0, and after 2 cycles t_i = 4'b1010, f_i = 4'b0101, ready_i = 1 → valid_o = 1 for one cycle with data_o = 4'hA; err_cnt_o = 0.
- Illegal pair: in EVAL drive t_i = 4'b0001, f_i = 4'b0001 → err_o pulse, err_code_o = 001, err_cnt_o = 1, no valid_o. The next completion is only accepted after a new precharge.
- Timeout: TIMEOUT = 8, rails stay 4'b0000 through evaluate → err_code_o = 010 eight cycles after entering EVAL, err_cnt_o = 1.
- Precharge violation: prechrg_i falls while t_i = 4'b0100 → err_code_o = 011, and no capture in that evaluate phase.
- Overrun: ready_i = 0, two successive cycles capture 4'h3 then 4'hC → data_o stays 4'h3, valid_o stays 1, err_code_o = 100. Raising ready_i then clears valid_o after 1 cycle.
- Reset mid-EVAL and saturation: assert rst_n = 0 during EVAL → all outputs 0 and state WAIT_PRE. With ERRCNT_W = 2, five errors → err_cnt_o = 3.

Source files
------------

// File: rtl/wddl_dr_rx_if.sv
// rtl/wddl_dr_rx_if.sv - dual-rail input and single-rail output bundle for wddl_dr_rx
interface wddl_dr_rx_if #(
    parameter int WIDTH    = 4,
    parameter int ERRCNT_W = 8
);
    logic                prechrg_i;
    logic [WIDTH-1:0]    t_i;
    logic [WIDTH-1:0]    f_i;
    logic [WIDTH-1:0]    data_o;
    logic                valid_o;
    logic                ready_i;
    logic                err_o;
    logic [2:0]          err_code_o;
    logic [ERRCNT_W-1:0] err_cnt_o;

    modport master (
        output prechrg_i, t_i, f_i, ready_i,
        input  data_o, valid_o, err_o, err_code_o, err_cnt_o
    );

    modport slave (
        input  prechrg_i, t_i, f_i, ready_i,
        output data_o, valid_o, err_o, err_code_o, err_cnt_o
    );
endinterface

// File: rtl/wddl_dr_rx.sv
// rtl/wddl_dr_rx.sv - WDDL dual-rail receiver with 1-entry output buffer; optional input sync via WDDL_RX_SYNC_EN
module wddl_dr_rx #(
    parameter int WIDTH    = 4,
    parameter int TIMEOUT  = 8,
    parameter int ERRCNT_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    wddl_dr_rx_if.slave     bus
);
    typedef enum logic [1:0] {WAIT_PRE, PRE, EVAL, DONE} state_t;

    logic             pre;
    logic [WIDTH-1:0] t_r;
    logic [WIDTH-1:0] f_r;

`ifdef WDDL_RX_SYNC_EN
    logic [1:0]       pre_s;
    logic [WIDTH-1:0] t_s1, t_s2, f_s1, f_s2;

    // two-flop synchronizers on the precharge strobe and both rails
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_s <= '0;
            t_s1  <= '0;
            t_s2  <= '0;
            f_s1  <= '0;
            f_s2  <= '0;
        end else begin
            pre_s <= {pre_s[0], bus.prechrg_i};
            t_s1  <= bus.t_i;
            t_s2  <= t_s1;
            f_s1  <= bus.f_i;
            f_s2  <= f_s1;
        end
    end

    assign pre = pre_s[1];
    assign t_r = t_s2;
    assign f_r = f_s2;
`else
    assign pre = bus.prechrg_i;
    assign t_r = bus.t_i;
    assign f_r = bus.f_i;
`endif

    logic any_ill, complete, zero;
    assign any_ill  = |(t_r & f_r);
    assign complete = &(t_r ^ f_r);
    assign zero     = ~|(t_r | f_r);

    state_t           state, state_nx;
    logic [7:0]       cnt, cnt_d;
    logic [8:0]       cnt_nx;
    logic             fsm_err, cap;
    logic [2:0]       fsm_code;
    logic             cap_vld;
    logic [WIDTH-1:0] cap_data;

    assign cnt_nx = {1'b0, cnt} + 9'd1;

    // next-state decode: illegal pair beats completion beats timeout/premature precharge
    always_comb begin
        state_nx = state;
        cnt_d    = cnt;
        fsm_err  = 1'b0;
        fsm_code = 3'b000;
        cap      = 1'b0;
        case (state)
            WAIT_PRE: if (pre) state_nx = PRE;
            PRE: begin
                if (!pre) begin
                    if (zero) begin
                        state_nx = EVAL;
                        cnt_d    = '0;
                    end else begin
                        fsm_err  = 1'b1;
                        fsm_code = 3'b011;
                        state_nx = WAIT_PRE;
                    end
                end
            end
            EVAL: begin
                cnt_d = cnt_nx[7:0];
                if (any_ill) begin
                    fsm_err  = 1'b1;
                    fsm_code = 3'b001;
                    state_nx = WAIT_PRE;
                end else if (complete) begin
                    cap      = 1'b1;
                    state_nx = DONE;
                end else if (cnt_nx >= 9'(TIMEOUT) || pre) begin
                    fsm_err  = 1'b1;
                    fsm_code = 3'b010;
                    state_nx = WAIT_PRE;
                end
            end
            DONE:    if (pre) state_nx = PRE;
            default: state_nx = WAIT_PRE;
        endcase
    end

    // FSM state, evaluate counter and one-stage capture pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= WAIT_PRE;
            cnt      <= '0;
            cap_vld  <= 1'b0;
            cap_data <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_d;
            cap_vld <= cap;
            if (cap) cap_data <= t_r;
        end
    end

    logic [WIDTH-1:0]    data_q;
    logic                valid_q, err_q;
    logic [2:0]          code_q;
    logic [ERRCNT_W-1:0] ecnt_q;
    logic                overrun, err_any;
    logic [2:0]          code_nx;

    // a capture can only land one cycle after EVAL, when the FSM sits in DONE and raises no error
    always_comb begin
        overrun = cap_vld && valid_q && !bus.ready_i;
        err_any = fsm_err || overrun;
        code_nx = overrun ? 3'b100 : fsm_code;
    end

    // output buffer, error pulse and saturating error counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 3'b000;
            ecnt_q  <= '0;
        end else begin
            if (cap_vld && (!valid_q || bus.ready_i)) begin
                data_q  <= cap_data;
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
            end
            err_q <= err_any;
            if (err_any) begin
                code_q <= code_nx;
                if (ecnt_q != '1) ecnt_q <= ecnt_q + 1'b1;
            end
        end
    end

    assign bus.data_o     = data_q;
    assign bus.valid_o    = valid_q;
    assign bus.err_o      = err_q;
    assign bus.err_code_o = code_q;
    assign bus.err_cnt_o  = ecnt_q;
endmodule

// File: tb/tb_wddl_dr_rx.sv
// tb/tb_wddl_dr_rx.sv - directed scoreboard bench for wddl_dr_rx
module tb_wddl_dr_rx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       prechrg;
    logic [3:0] t, f;
    logic       ready;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] data_q[$];
    logic [31:0] err_q[$];

    wddl_dr_rx_if #(.WIDTH(4), .ERRCNT_W(8)) bus1 ();
    wddl_dr_rx_if #(.WIDTH(4), .ERRCNT_W(2)) bus2 ();

    assign bus1.prechrg_i = prechrg;
    assign bus1.t_i       = t;
    assign bus1.f_i       = f;
    assign bus1.ready_i   = ready;
    assign bus2.prechrg_i = prechrg;
    assign bus2.t_i       = t;
    assign bus2.f_i       = f;
    assign bus2.ready_i   = ready;

    wddl_dr_rx #(.WIDTH(4), .TIMEOUT(8), .ERRCNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    wddl_dr_rx #(.WIDTH(4), .TIMEOUT(8), .ERRCNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic enter_eval();
        prechrg = 1'b1;
        t = 4'h0;
        f = 4'h0;
        cyc(2);
        prechrg = 1'b0;
        cyc(1);
    endtask

    // scoreboard: pop expected error codes and accepted data as the DUT produces them
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n) begin
            if (bus1.err_o) begin
                e = (err_q.size() > 0) ? err_q.pop_front() : 32'hdead_beef;
                chk("sb_err_code", 32'(bus1.err_code_o), e);
            end
            if (bus1.valid_o && bus1.ready_i) begin
                e = (data_q.size() > 0) ? data_q.pop_front() : 32'hdead_beef;
                chk("sb_data", 32'(bus1.data_o), e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; prechrg = 1'b0; t = 4'h0; f = 4'h0; ready = 1'b1;
        cyc(2);
        chk("rst_data",  32'(bus1.data_o), 0);
        chk("rst_valid", 32'(bus1.valid_o), 0);
        chk("rst_err",   32'(bus1.err_o), 0);
        chk("rst_code",  32'(bus1.err_code_o), 0);
        chk("rst_cnt",   32'(bus1.err_cnt_o), 0);
        rst_n = 1'b1;

        // normal capture
        enter_eval();
        cyc(2);
        t = 4'b1010; f = 4'b0101;
        data_q.push_back(32'hA);
        cyc(1);
        chk("norm_latency_valid", 32'(bus1.valid_o), 0);
        cyc(1);
        chk("norm_valid", 32'(bus1.valid_o), 1);
        chk("norm_data",  32'(bus1.data_o), 32'hA);
        cyc(1);
        chk("norm_valid_clr", 32'(bus1.valid_o), 0);
        chk("norm_cnt", 32'(bus1.err_cnt_o), 0);

        // illegal pair, then completion ignored until a new precharge
        enter_eval();
        t = 4'b0001; f = 4'b0001;
        err_q.push_back(32'd1);
        cyc(1);
        chk("ill_err",  32'(bus1.err_o), 1);
        chk("ill_code", 32'(bus1.err_code_o), 1);
        chk("ill_cnt",  32'(bus1.err_cnt_o), 1);
        t = 4'b1010; f = 4'b0101;
        cyc(3);
        chk("ill_no_valid", 32'(bus1.valid_o), 0);
        chk("ill_no_err",   32'(bus1.err_o), 0);

        // timeout after exactly TIMEOUT evaluate cycles
        enter_eval();
        cyc(7);
        chk("to_early", 32'(bus1.err_o), 0);
        err_q.push_back(32'd2);
        cyc(1);
        chk("to_err",  32'(bus1.err_o), 1);
        chk("to_code", 32'(bus1.err_code_o), 2);
        chk("to_cnt",  32'(bus1.err_cnt_o), 2);
        cyc(1);
        chk("to_pulse_1cyc", 32'(bus1.err_o), 0);
        chk("to_code_hold",  32'(bus1.err_code_o), 2);

        // premature precharge, then WAIT_PRE -> PRE -> EVAL recovers
        enter_eval();
        cyc(1);
        prechrg = 1'b1;
        err_q.push_back(32'd2);
        cyc(1);
        chk("pp_err", 32'(bus1.err_o), 1);
        chk("pp_cnt", 32'(bus1.err_cnt_o), 3);
        cyc(1);
        prechrg = 1'b0;
        cyc(1);
        t = 4'b0110; f = 4'b1001;
        data_q.push_back(32'h6);
        cyc(2);
        chk("pp_valid", 32'(bus1.valid_o), 1);
        chk("pp_data",  32'(bus1.data_o), 32'h6);

        // precharge violation
        prechrg = 1'b1; t = 4'h0; f = 4'h0;
        cyc(2);
        t = 4'b0100;
        cyc(1);
        prechrg = 1'b0;
        err_q.push_back(32'd3);
        cyc(1);
        chk("pv_err",  32'(bus1.err_o), 1);
        chk("pv_code", 32'(bus1.err_code_o), 3);
        chk("pv_cnt",  32'(bus1.err_cnt_o), 4);
        t = 4'b1010; f = 4'b0101;
        cyc(3);
        chk("pv_no_valid", 32'(bus1.valid_o), 0);

        // overrun
        ready = 1'b0;
        enter_eval();
        t = 4'h3; f = 4'hC;
        data_q.push_back(32'h3);
        cyc(1);
        prechrg = 1'b1; t = 4'h0; f = 4'h0;
        cyc(1);
        chk("ov_first_valid", 32'(bus1.valid_o), 1);
        prechrg = 1'b0;
        cyc(1);
        t = 4'hC; f = 4'h3;
        cyc(1);
        err_q.push_back(32'd4);
        cyc(1);
        chk("ov_err",   32'(bus1.err_o), 1);
        chk("ov_code",  32'(bus1.err_code_o), 4);
        chk("ov_cnt",   32'(bus1.err_cnt_o), 5);
        chk("ov_data",  32'(bus1.data_o), 32'h3);
        chk("ov_valid", 32'(bus1.valid_o), 1);
        chk("ov_sat_cnt", 32'(bus2.err_cnt_o), 3);
        cyc(2);
        chk("ov_stable", 32'(bus1.data_o), 32'h3);
        ready = 1'b1;
        cyc(1);
        chk("ov_clear", 32'(bus1.valid_o), 0);

        // one more error: wide counter keeps counting, narrow one stays saturated
        enter_eval();
        t = 4'b1000; f = 4'b1000;
        err_q.push_back(32'd1);
        cyc(1);
        chk("sat_cnt_wide",   32'(bus1.err_cnt_o), 6);
        chk("sat_cnt_narrow", 32'(bus2.err_cnt_o), 3);

        // reset mid-EVAL with pending data
        ready = 1'b0;
        enter_eval();
        t = 4'b0101; f = 4'b1010;
        cyc(1);
        prechrg = 1'b1; t = 4'h0; f = 4'h0;
        cyc(1);
        chk("rr_pending", 32'(bus1.valid_o), 1);
        prechrg = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        chk("rr_data",  32'(bus1.data_o), 0);
        chk("rr_valid", 32'(bus1.valid_o), 0);
        chk("rr_err",   32'(bus1.err_o), 0);
        chk("rr_code",  32'(bus1.err_code_o), 0);
        chk("rr_cnt",   32'(bus1.err_cnt_o), 0);
        chk("rr_cnt2",  32'(bus2.err_cnt_o), 0);
        rst_n = 1'b1;
        t = 4'b1010; f = 4'b0101;
        cyc(3);
        chk("rr_waitpre_valid", 32'(bus1.valid_o), 0);
        chk("rr_waitpre_err",   32'(bus1.err_o), 0);

        // all-zero word after reset
        ready = 1'b1;
        enter_eval();
        t = 4'h0; f = 4'hF;
        data_q.push_back(32'h0);
        cyc(2);
        chk("zw_valid", 32'(bus1.valid_o), 1);
        chk("zw_data",  32'(bus1.data_o), 0);
        cyc(2);
        chk("sb_data_drained", 32'(data_q.size()), 0);
        chk("sb_err_drained",  32'(err_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
